fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Reader/drain end of the gen_fifo push/pop interface. Pops the FIFO head (fall-through data_pop)
//  whenever internal space exists and re-presents entries downstream as a valid/ready stream via a
//  2-entry skid buffer, so downstream m_ready never reaches fifo_pop combinationally.
//  Sits between an issue/commit FIFO and its consumer stage; shares the flush with the FIFO.
// PARAMETERS
//  DW  64  entry width; must match the DW of the connected gen_fifo
// PORTS
//  CLK         in   1   clock, rising edge
//  RSTn        in   1   synchronous reset, active low
//  flush       in   1   pipeline flush; same signal that drives the FIFO's flush
//  fifo_empty  in   1   FIFO empty flag
//  data_pop    in   DW  FIFO head data, valid while fifo_empty==0
//  fifo_pop    out  1   pop strobe to FIFO
//  m_valid     out  1   downstream entry valid
//  m_ready     in   1   downstream accepts
//  m_data      out  DW  downstream entry (slot0)
//  occupancy   out  2   skid entries held (0..2)
//  beat_cnt    out  32  delivered beats (perf)
//  stall_cnt   out  32  cycles with m_valid & ~m_ready (perf)
// BEHAVIOUR
//  - One clock CLK; reset synchronous, active-low on RSTn. At reset: occ=0 (EMPTY), slot0/slot1=0,
//    m_valid=0, m_data=0, fifo_pop=0, beat_cnt=0, stall_cnt=0.
//  - States EMPTY(occ0)/ONE(occ1)/TWO(occ2). m_data=slot0. m_valid=(occ!=0)&~flush.
//  - fifo_pop = RSTn & ~flush & ~fifo_empty & (occ!=2); depends only on registered state + FIFO flag.
//  - fire = m_valid & m_ready. occ_next = occ + pop - fire.
//  - Data moves (one cycle latency FIFO head -> m_data):
//    EMPTY & pop          : slot0<=data_pop -> ONE
//    ONE & pop & fire     : slot0<=data_pop, stay ONE (1 beat/cycle sustained)
//    ONE & pop & ~fire    : slot1<=data_pop -> TWO
//    ONE & ~pop & fire    : -> EMPTY
//    TWO & fire           : slot0<=slot1 -> ONE (no pop in TWO)
//    otherwise hold; m_data stable while m_valid & ~m_ready.
//  - Order strictly FIFO; no entry dropped or duplicated outside flush.
//  - flush: occ<=EMPTY next cycle, slots' contents don't-care, no pop, no fire in flush cycle.
//    flush overrides pop/fire; entries in flight are discarded.
//  - Reset mid-transfer: same as flush plus counters cleared.
// CONFIGURATION
//  FIFO_STREAM_READER_PERF_EN defined: beat_cnt +1 per fire, stall_cnt +1 per m_valid&~m_ready
//    cycle; both 32-bit, wrap 0xFFFF_FFFF->0, cleared by reset only (not flush).
//  Not defined: counter flops absent; beat_cnt/stall_cnt tied to 0.
// STRUCTURE
//  - Shared package/header: state encodings OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2; perf width 32.
//  - Sub-module: gen_dffr for all registers; no other hierarchy.
// TESTING
//  1 Reset: RSTn=0 2 cycles, fifo_empty=0 -> fifo_pop=0, m_valid=0, occupancy=0, counters 0.
//  2 Streaming: FIFO holds 0x11..0x18, m_ready=1 -> first m_valid 1 cycle after first pop;
//    8 beats on 8 consecutive cycles, in order; beat_cnt=8 (PERF_EN).
//  3 Backpressure: m_ready=0 with FIFO non-empty -> exactly 2 pops, occupancy=2, fifo_pop=0,
//    m_data=0x11 stable; m_ready=1 -> 0x11, 0x12, 0x13... no gap, no loss; stall_cnt=cycles held.
//  4 Flush in TWO: occ=2, assert flush 1 cycle with m_ready=1 -> no fire that cycle, m_valid=0 and
//    occupancy=0 next cycle; post-flush pushes 0xA0,0xA1 delivered in order.
//  5 Empty toggling: fifo_empty alternates each cycle, m_ready random 50% -> scoreboard matches
//    push order exactly; fifo_pop never asserted while fifo_empty=1 or occupancy=2.
//  6 Wrap: preload beat_cnt near 0xFFFF_FFFF by force, 2 fires -> reads 0x0000_0000 then 0x1.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared encodings and widths for the FIFO stream reader
package fifo_stream_reader_pkg;

  // Skid-buffer occupancy states; the encoding equals the number of held entries.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Width of the performance counters.
  localparam int PERF_W = 32;

  // True when the skid buffer has no room for another FIFO entry.
  function automatic logic occ_full(input occ_e occ);
    return (occ == OCC_TWO);
  endfunction

  // True when slot0 holds an entry to present downstream.
  function automatic logic occ_has_data(input occ_e occ);
    return (occ != OCC_EMPTY);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO pop side and downstream stream side of the reader
interface fifo_stream_reader_if #(
  parameter int DW = 64
);

  // FIFO side: fall-through head data plus empty flag, pop strobe back.
  logic          fifo_empty;
  logic [DW-1:0] data_pop;
  logic          fifo_pop;

  // Downstream side: valid/ready stream.
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  // The reader itself: consumes the FIFO, sources the stream.
  modport master (
    input  fifo_empty,
    input  data_pop,
    output fifo_pop,
    output m_valid,
    input  m_ready,
    output m_data
  );

  // The environment: the FIFO and the downstream consumer.
  modport slave (
    output fifo_empty,
    output data_pop,
    input  fifo_pop,
    input  m_valid,
    output m_ready,
    input  m_data
  );

endinterface

// File: rtl/fifo_stream_reader_gen_dffr.sv
// rtl/fifo_stream_reader_gen_dffr.sv - gen_dffr: enabled register with synchronous active-low reset
module gen_dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load on enable; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a fall-through FIFO into a 2-entry skid buffer feeding a valid/ready stream; optional perf counters under FIFO_STREAM_READER_PERF_EN
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              flush,
  fifo_stream_reader_if.master bus,
  output logic [1:0]        occupancy,
  output logic [PERF_W-1:0] beat_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  // Registered state (all held in gen_dffr instances).
  logic [1:0]    r_occ;
  logic [DW-1:0] r_slot0;
  logic [DW-1:0] r_slot1;

  // Next-state controls.
  occ_e          w_occ;
  occ_e          w_occ_next;
  logic [1:0]    w_occ_next_bits;
  logic          w_slot0_en;
  logic          w_slot1_en;
  logic [DW-1:0] w_slot0_d;
  logic [DW-1:0] w_slot1_d;

  // Handshake terms.
  logic          w_pop;
  logic          w_valid;
  logic          w_fire;
  logic          w_stall;

  assign w_occ = occ_e'(r_occ);

  // Pop only depends on registered occupancy and the FIFO flag, never on m_ready,
  // so the downstream ready path is cut at the skid buffer.
  assign w_pop   = RSTn & ~flush & ~bus.fifo_empty & ~occ_full(w_occ);
  assign w_valid = RSTn & ~flush & occ_has_data(w_occ);
  assign w_fire  = w_valid & bus.m_ready;
  assign w_stall = w_valid & ~bus.m_ready;

  // Skid-buffer transitions: slot0 is always the stream head, slot1 only catches
  // the entry popped while the head is stalled.
  always_comb begin
    w_occ_next = w_occ;
    w_slot0_en = 1'b0;
    w_slot1_en = 1'b0;
    w_slot0_d  = bus.data_pop;
    w_slot1_d  = bus.data_pop;
    if (flush) begin
      w_occ_next = OCC_EMPTY;
    end else begin
      case (w_occ)
        OCC_EMPTY: begin
          if (w_pop) begin
            w_slot0_en = 1'b1;
            w_occ_next = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_pop && w_fire) begin
            w_slot0_en = 1'b1;
          end else if (w_pop) begin
            w_slot1_en = 1'b1;
            w_occ_next = OCC_TWO;
          end else if (w_fire) begin
            w_occ_next = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_fire) begin
            w_slot0_en = 1'b1;
            w_slot0_d  = r_slot1;
            w_occ_next = OCC_ONE;
          end
        end
        default: begin
          w_occ_next = OCC_EMPTY;
        end
      endcase
    end
  end

  assign w_occ_next_bits = w_occ_next;

  gen_dffr #(.W(2)) u_occ (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_en (1'b1),
    .i_d  (w_occ_next_bits),
    .o_q  (r_occ)
  );

  gen_dffr #(.W(DW)) u_slot0 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_en (w_slot0_en),
    .i_d  (w_slot0_d),
    .o_q  (r_slot0)
  );

  gen_dffr #(.W(DW)) u_slot1 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_en (w_slot1_en),
    .i_d  (w_slot1_d),
    .o_q  (r_slot1)
  );

`ifdef FIFO_STREAM_READER_PERF_EN
  logic [PERF_W-1:0] w_beat_q;
  logic [PERF_W-1:0] w_stall_q;

  // Counters wrap naturally and are only cleared by reset, not by flush.
  gen_dffr #(.W(PERF_W)) u_beat_cnt (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_en (w_fire),
    .i_d  (w_beat_q + PERF_W'(1)),
    .o_q  (w_beat_q)
  );

  gen_dffr #(.W(PERF_W)) u_stall_cnt (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_en (w_stall),
    .i_d  (w_stall_q + PERF_W'(1)),
    .o_q  (w_stall_q)
  );

  assign beat_cnt  = w_beat_q;
  assign stall_cnt = w_stall_q;
`else
  logic w_perf_unused;
  assign w_perf_unused = w_stall;
  assign beat_cnt      = '0;
  assign stall_cnt     = '0;
`endif

  assign bus.fifo_pop = w_pop;
  assign bus.m_valid  = w_valid;
  assign bus.m_data   = r_slot0;
  assign occupancy    = r_occ;

endmodule
